// File: rtl/register_file_pkg.sv
// Shared Y86-64 register-file definitions: word width, register IDs and the
// icode values that decode and write-back use when picking dstE/dstM/srcA/srcB.
package register_file_pkg;

  localparam int WORD_W   = 64;
  localparam int REG_ID_W = 4;
  localparam int NUM_REGS = 15;

  localparam logic [REG_ID_W-1:0] RAX   = 4'h0;
  localparam logic [REG_ID_W-1:0] RCX   = 4'h1;
  localparam logic [REG_ID_W-1:0] RDX   = 4'h2;
  localparam logic [REG_ID_W-1:0] RBX   = 4'h3;
  localparam logic [REG_ID_W-1:0] RSP   = 4'h4;
  localparam logic [REG_ID_W-1:0] RBP   = 4'h5;
  localparam logic [REG_ID_W-1:0] RSI   = 4'h6;
  localparam logic [REG_ID_W-1:0] RDI   = 4'h7;
  localparam logic [REG_ID_W-1:0] R8    = 4'h8;
  localparam logic [REG_ID_W-1:0] R9    = 4'h9;
  localparam logic [REG_ID_W-1:0] R10   = 4'hA;
  localparam logic [REG_ID_W-1:0] R11   = 4'hB;
  localparam logic [REG_ID_W-1:0] R12   = 4'hC;
  localparam logic [REG_ID_W-1:0] R13   = 4'hD;
  localparam logic [REG_ID_W-1:0] R14   = 4'hE;
  localparam logic [REG_ID_W-1:0] RNONE = 4'hF;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef struct packed {
    logic [REG_ID_W-1:0] dst;
    logic [WORD_W-1:0]   val;
  } wr_port_t;

  function automatic logic is_reg(input logic [REG_ID_W-1:0] id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/register_file.sv
// Y86-64 register file: 15 x 64-bit registers, two write ports (E, M), two
// combinational read ports, optional same-cycle write forwarding.
module register_file
  import register_file_pkg::*;
#(
  parameter bit BYPASS = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [REG_ID_W-1:0] dstE,
  input  logic [WORD_W-1:0]   valE,
  input  logic [REG_ID_W-1:0] dstM,
  input  logic [WORD_W-1:0]   valM,
  input  logic [REG_ID_W-1:0] srcA,
  input  logic [REG_ID_W-1:0] srcB,
  output logic [WORD_W-1:0]   valA,
  output logic [WORD_W-1:0]   valB,
  output logic [15:0]         wr_count
);

  logic [NUM_REGS-1:0][WORD_W-1:0] regs;
  wr_port_t pe, pm;
  logic     wr_ok, we_e, we_m;

  assign pe    = '{dst: dstE, val: valE};
  assign pm    = '{dst: dstM, val: valM};
  assign wr_ok = rst_n && !stall;
  assign we_m  = wr_ok && is_reg(pm.dst);
  // M port wins a collision, so E is dropped when both target one register
  assign we_e  = wr_ok && is_reg(pe.dst) && (pe.dst != pm.dst);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n)
        regs[g] <= '0;
      else if (we_m && pm.dst == REG_ID_W'(g))
        regs[g] <= pm.val;
      else if (we_e && pe.dst == REG_ID_W'(g))
        regs[g] <= pe.val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      wr_count <= '0;
    else if (we_e || we_m)
      wr_count <= wr_count + 16'd1;
  end

  always_comb begin
    valA = '0;
    valB = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (srcA == REG_ID_W'(i)) valA = regs[i];
      if (srcB == REG_ID_W'(i)) valB = regs[i];
    end
    if (BYPASS) begin
      if (we_m && pm.dst == srcA)      valA = pm.val;
      else if (we_e && pe.dst == srcA) valA = pe.val;
      if (we_m && pm.dst == srcB)      valB = pm.val;
      else if (we_e && pe.dst == srcB) valB = pe.val;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: drives a BYPASS=0 and a BYPASS=1 register file in lockstep
// and checks both against an array-based model of the register file rules.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n, stall;
  logic [3:0]  dstE, dstM, srcA, srcB;
  logic [63:0] valE, valM;
  logic [63:0] valA0, valB0, valA1, valB1;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  register_file #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .srcA(srcA), .srcB(srcB), .valA(valA0), .valB(valB0), .wr_count(cnt0));

  register_file #(.BYPASS(1'b1)) u_by (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .srcA(srcA), .srcB(srcB), .valA(valA1), .valB(valB1), .wr_count(cnt1));

  typedef struct {
    logic [63:0] a0, b0, a1, b1;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m[15];
  logic [15:0] m_cnt;
  bit          known = 0;
  int          n_chk = 0, n_pass = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("valA_nobyp", valA0, e.a0);
      cmp("valB_nobyp", valB0, e.b0);
      cmp("valA_byp",   valA1, e.a1);
      cmp("valB_byp",   valB1, e.b1);
      cmp("wrcnt_nobyp", {48'h0, cnt0}, {48'h0, e.cnt});
      cmp("wrcnt_byp",   {48'h0, cnt1}, {48'h0, e.cnt});
    end
  end

  // Read as seen during the cycle: forwarding only if a real write happens now
  function automatic logic [63:0] model_rd(input logic [3:0] id, input bit byp,
                                           input bit r, input bit st,
                                           input logic [3:0] de, input logic [63:0] ve,
                                           input logic [3:0] dm, input logic [63:0] vm);
    if (id == 4'hF) return 64'h0;
    if (byp && r && !st) begin
      if (dm == id) return vm;
      if (de == id) return ve;
    end
    return m[id];
  endfunction

  task automatic cyc(input bit r, input bit st,
                     input logic [3:0] de, input logic [63:0] ve,
                     input logic [3:0] dm, input logic [63:0] vm,
                     input logic [3:0] sa, input logic [3:0] sb, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; stall = st; dstE = de; valE = ve; dstM = dm; valM = vm;
    srcA = sa; srcB = sb;
    if (chk && known && r) begin
      e.a0  = model_rd(sa, 0, r, st, de, ve, dm, vm);
      e.b0  = model_rd(sb, 0, r, st, de, ve, dm, vm);
      e.a1  = model_rd(sa, 1, r, st, de, ve, dm, vm);
      e.b1  = model_rd(sb, 1, r, st, de, ve, dm, vm);
      e.cnt = m_cnt;
      q.push_back(e);
    end
    // state after the coming edge
    if (!r) begin
      for (int i = 0; i < 15; i++) m[i] = 64'h0;
      m_cnt = 16'h0;
      known = 1;
    end else if (!st) begin
      if (de != 4'hF) m[de] = ve;
      if (dm != 4'hF) m[dm] = vm;
      if (de != 4'hF || dm != 4'hF) m_cnt = m_cnt + 16'h1;
    end
  endtask

  task automatic rd(input logic [3:0] sa, input logic [3:0] sb);
    cyc(1, 0, 4'hF, 64'h0, 4'hF, 64'h0, sa, sb, 1);
  endtask

  initial begin
    logic [3:0]  de, dm, sa, sb;
    logic [63:0] ve, vm;
    bit          r, st;
    rst_n = 0; stall = 0; dstE = 4'hF; dstM = 4'hF; valE = 0; valM = 0;
    srcA = 0; srcB = 0;

    // reset then read
    cyc(0, 0, 4'hF, 0, 4'hF, 0, 0, 14, 1);
    rd(0, 14);
    // dual write
    cyc(1, 0, 2, 64'h11, 3, 64'h22, 2, 3, 1);
    rd(2, 3);
    // collision: M wins
    cyc(1, 0, 4, 64'hAA, 4, 64'hBB, 4, 15, 1);
    rd(4, 15);
    // stall, then RNONE-only writes
    cyc(1, 1, 5, 64'h7, 4'hF, 0, 5, 4, 1);
    rd(5, 15);
    cyc(1, 0, 4'hF, 64'h99, 4'hF, 64'h98, 15, 5, 1);
    rd(15, 4);
    // one real port plus an RNONE port still counts
    cyc(1, 0, 4'hF, 64'h1, 7, 64'h77, 7, 7, 1);
    rd(7, 0);
    // same-cycle forwarding vs. old value
    cyc(1, 0, 6, 64'h55, 4'hF, 0, 6, 6, 1);
    rd(6, 6);

    // random mix of writes, collisions, stalls and occasional resets
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      st = ($urandom_range(0, 4) == 0);
      de = 4'($urandom_range(0, 15));
      dm = ($urandom_range(0, 3) == 0) ? de : 4'($urandom_range(0, 15));
      sa = ($urandom_range(0, 2) == 0) ? de : 4'($urandom_range(0, 15));
      sb = ($urandom_range(0, 2) == 0) ? dm : 4'($urandom_range(0, 15));
      ve = {$urandom, $urandom};
      vm = {$urandom, $urandom};
      cyc(r, st, de, ve, dm, vm, sa, sb, 1);
    end

    // preload the counter up to its wrap point
    while (m_cnt != 16'hFFFF)
      cyc(1, 0, 4'($urandom_range(0, 14)), {$urandom, $urandom}, 4'hF, 0, 0, 0, 0);
    rd(1, 2);
    cyc(1, 0, 1, 64'hDEAD_BEEF_0123_4567, 4'hF, 0, 1, 3, 1);
    rd(1, 3);
    // mid-run reset discards the concurrent write
    cyc(0, 0, 1, 64'h1234, 2, 64'h5678, 1, 2, 1);
    rd(1, 2);
    rd(14, 15);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter BYPASS, default 0; 1 = same-cycle write data forwarded to read ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 stall  input  1  1 = suppress all register writes this cycle.
REQ-005 dstE  input  4  destination register ID for valE; 4'hF = none.
REQ-006 valE  input  64  ALU result to write.
REQ-007 dstM  input  4  destination register ID for valM; 4'hF = none.
REQ-008 valM  input  64  memory result to write.
REQ-009 srcA  input  4  read register ID, port A; 4'hF = none.
REQ-010 srcB  input  4  read register ID, port B; 4'hF = none.
REQ-011 valA  output  64  port A read data.
REQ-012 valB  output  64  port B read data.
REQ-013 wr_count  output  16  count of cycles in which at least one register was written.

Function
REQ-014 Storage: 15 registers, 64 bits each, IDs 0..14 (%rax..%r14); ID 15 is RNONE and has no storage.
REQ-015 Reads: combinational; valA = reg[srcA], valB = reg[srcB]; RNONE reads 64'h0.
REQ-016 BYPASS=1: a read of an ID being written this cycle returns the incoming write data; priority follows REQ-019.
REQ-017 BYPASS=0: a read of an ID being written this cycle returns the old value; the new value is visible the cycle after the edge.
REQ-018 Writes: on a rising clk with rst_n=1 and stall=0, reg[dstE]<=valE if dstE!=15, and reg[dstM]<=valM if dstM!=15.
REQ-019 dstE==dstM!=15 in the same cycle: only valM is written (popq %rsp rule: M port wins).
REQ-020 stall=1: no register changes and wr_count holds; reads are still served.
REQ-021 wr_count increments by 1 on each edge where rst_n=1, stall=0 and (dstE!=15 or dstM!=15).
REQ-022 wr_count wraps from 16'hFFFF to 0 without flagging.
REQ-023 Writes to RNONE are ignored and are not counted unless the other port is a real write.
REQ-024 Read and write IDs are 4-bit exact; there are no width extensions and no masking of data.

Reset
REQ-025 When rst_n=0 at a rising clk, all 15 registers and wr_count are cleared to 0, overriding stall and any pending writes.
REQ-026 Reset asserted mid-operation discards that cycle's writes; valA/valB read 0 from the next cycle.
REQ-027 Before the first reset edge, register contents are undefined; the bench issues reset first.

Structure
REQ-028 A shared package holds the RNONE=4'hF constant, register ID constants (RSP=4), the 64-bit word width and the icode constants shared with decode/write-back.
REQ-029 The block is a single module with no sub-modules; storage is a 15-entry array.

Verification
REQ-030 Reset then read: after rst_n=0 for 1 cycle, srcA=0, srcB=14 -> valA=0, valB=0, wr_count=0.
REQ-031 Dual write: dstE=2, valE=64'h11, dstM=3, valM=64'h22 for one edge; then srcA=2, srcB=3 -> valA=64'h11, valB=64'h22, wr_count=1.
REQ-032 Collision: dstE=dstM=4, valE=64'hAA, valM=64'hBB -> reg4=64'hBB, wr_count+1.
REQ-033 Stall/RNONE: stall=1 with dstE=5, valE=64'h7 -> reg5 unchanged and count unchanged; stall=0 with dstE=dstM=15 -> no change and count unchanged; RNONE read returns 0.
REQ-034 Bypass: BYPASS=1, dstE=6, valE=64'h55, srcA=6 in the same cycle -> valA=64'h55 before the edge; BYPASS=0 -> old value before the edge, 64'h55 after it.
REQ-035 Mid-run reset plus wrap: preload wr_count to 16'hFFFF via writes, one more write -> 0; assert rst_n=0 with dstE=1 -> reg1=0.
